uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serializes one parallel byte into an asynchronous UART frame on a single line: start bit (0), data LSB first, optional parity, stop bit (1). It is the transmit end of the team's UART link and pairs with the existing UART receiver. The line idles high. A baud divider inside the block holds each bit for CLKS_PER_BIT clocks.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); 1 = one bit per clk, matching the receiver's current timing

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to send tx_data; sampled only when busy=0
tx_data  input  DATA_BITS  byte to send; latched on the accepting edge
tx_out  output  1  serial line; idle high
busy  output  1  high while a frame is in progress
done  output  1  single-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; tx_out=1, busy=0, done=0; bit counter, baud counter and shift register cleared. This applies at any time, including mid-frame. The line returns high on that edge and the partial frame is abandoned.
- rst has priority over start on the same edge.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: tx_out=1, busy=0. On an edge with start=1:
  - latch tx_data into the shift register;
  - tx_out<=0, busy<=1, baud_cnt<=0, go to START.
- Bit timing: each state holds tx_out for exactly CLKS_PER_BIT cycles.
  - baud_cnt counts 0..CLKS_PER_BIT-1.
  - On the edge where baud_cnt==CLKS_PER_BIT-1, advance to the next bit and reset baud_cnt to 0.
  - baud_cnt width is clog2(CLKS_PER_BIT), minimum 1.
- START -> DATA: tx_out<=shreg[0] and bit_idx<=0.
- DATA: on each bit boundary, shift right and drive the next LSB, bit_idx++.
  - After bit DATA_BITS-1 completes: go to PARITY if enabled, else STOP with tx_out<=1.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. On its final edge:
  - state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Frame length: (DATA_BITS+2) x CLKS_PER_BIT cycles from the accepting edge to the edge asserting done. It is (DATA_BITS+3) x CLKS_PER_BIT with parity.
- start while busy=1 is ignored; no queuing. Changes on tx_data after acceptance have no effect.
- Back-to-back frames: start=1 in the cycle done=1 (busy=0) is accepted. The next start bit begins with no idle gap beyond the stop bit.
- done is 0 in every cycle except the one after stop completion.
- Outputs are registered. tx_out has no combinational path from any input.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx_out = even parity, i.e. the XOR of all latched data bits.
  - The parity value is computed from the latched word at acceptance.
- Not defined: there is no PARITY state or parity logic, and the frame goes directly DATA -> STOP.

Test Plan:
1. CLKS_PER_BIT=1, rst held 2 cycles then released, start=0 -> tx_out=1, busy=0, done=0 continuously for 20 cycles.
2. Send 0xA5 with CLKS_PER_BIT=1 (start for 1 cycle):
   - tx_out in the 10 cycles after the accepting edge = 0,1,0,1,0,0,1,0,1,1;
   - busy=1 for those 10 cycles;
   - done=1 in the next cycle only;
   - the monitored FSM state sequence is IDLE, START, DATA x8, STOP, IDLE.
3. CLKS_PER_BIT=4, send 0x01 -> start bit low for 4 cycles, bit0 high for 4 cycles, seven data bits low for 28 cycles, stop high for 4 cycles; done 40 cycles after acceptance.
4. Busy and back-to-back handling:
   - send 0x3C; pulse start with tx_data=0xFF mid-frame -> ignored, and the frame still carries 0x3C;
   - assert start with 0xC3 during the done cycle -> 0xC3 starts immediately, with no extra idle cycle.
5. Send 0x00 and assert rst during data bit 3 -> tx_out=1, busy=0 on that edge and done never pulses. A following start with 0x55 produces a clean, complete frame.
6. With UART_TX_PARITY_EN defined:
   - 0xA5 -> parity bit 0 in cycle 10, then stop, and done after 11 cycles;
   - 0x07 -> parity bit 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit end: serializes a DATA_BITS word as start(0), data LSB first, stop(1), each bit held CLKS_PER_BIT clocks.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the last data bit and the stop bit.
module uart_transmitter #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == S_IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (start) begin
                shreg_d = tx_data;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                baud_d  = '0;
                state_d = S_START;
`ifdef UART_TX_PARITY_EN
                parity_d = ^tx_data;
`endif
            end
        end else if (!bit_end) begin
            baud_d = baud_q + 1'b1;
        end else begin
            // Bit boundary: every non-idle state advances here.
            baud_d = '0;
            case (state_q)
                S_START: begin
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: one instance at 1 clk/bit, one at 4 clk/bit.
// Expectations follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NFRAME = 11;
`else
    localparam int NFRAME = 10;
`endif

    logic       clk;
    logic       rst;
    logic       start1, start4;
    logic [7:0] d1, d4;
    logic       tx1, busy1, done1;
    logic       tx4, busy4, done4;
    logic [10:0] got;
    int         vectors;
    int         miscompares;

    uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(d1),
        .tx_out(tx1), .busy(busy1), .done(done1)
    );

    uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .tx_data(d4),
        .tx_out(tx4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level of bit slot k of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the first sample after the accepting edge; returns at the done-cycle sample.
    task automatic check_frame1(input logic [7:0] d, input string tag, input bit inject,
                                output logic [10:0] bits);
        bits = '0;
        for (int k = 0; k < NFRAME; k++) begin
            bits[k] = tx1;
            chk($sformatf("%s tx k%0d", tag, k), 32'(tx1), 32'(frame_bit(d, k)));
            chk($sformatf("%s busy k%0d", tag, k), 32'(busy1), 32'd1);
            chk($sformatf("%s done k%0d", tag, k), 32'(done1), 32'd0);
            if (inject && k == 3) begin
                start1 = 1'b1;
                d1     = 8'hFF;
            end
            if (inject && k == 4) start1 = 1'b0;
            @(negedge clk);
        end
        chk({tag, " done pulse"}, 32'(done1), 32'd1);
        chk({tag, " busy at done"}, 32'(busy1), 32'd0);
        chk({tag, " tx at done"}, 32'(tx1), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        d1     = 8'h00;
        d4     = 8'h00;

        // 1: reset then quiet idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle tx1 c%0d", i), 32'(tx1), 32'd1);
            chk($sformatf("idle busy1 c%0d", i), 32'(busy1), 32'd0);
            chk($sformatf("idle done1 c%0d", i), 32'(done1), 32'd0);
            chk($sformatf("idle tx4 c%0d", i), 32'(tx4), 32'd1);
            chk($sformatf("idle busy4 c%0d", i), 32'(busy4), 32'd0);
            @(negedge clk);
        end

        // 2: 0xA5 at one clk per bit
        start1 = 1'b1;
        d1     = 8'hA5;
        @(negedge clk);
        start1 = 1'b0;
        check_frame1(8'hA5, "a5", 1'b0, got);
`ifdef UART_TX_PARITY_EN
        chk("a5 frame bits", 32'(got), 32'(11'b10101001010));
`else
        chk("a5 frame bits", 32'(got[9:0]), 32'(10'b1101001010));
`endif
        @(negedge clk);
        chk("a5 done single", 32'(done1), 32'd0);

        // 3: 0x01 at four clks per bit
        start4 = 1'b1;
        d4     = 8'h01;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 0; c < NFRAME * 4; c++) begin
            chk($sformatf("x4 tx c%0d", c), 32'(tx4), 32'(frame_bit(8'h01, c / 4)));
            chk($sformatf("x4 busy c%0d", c), 32'(busy4), 32'd1);
            chk($sformatf("x4 done c%0d", c), 32'(done4), 32'd0);
            @(negedge clk);
        end
        chk("x4 done pulse", 32'(done4), 32'd1);
        @(negedge clk);
        chk("x4 done single", 32'(done4), 32'd0);
        chk("x4 idle tx", 32'(tx4), 32'd1);

        // 4: start while busy ignored; start in the done cycle chains a frame
        start1 = 1'b1;
        d1     = 8'h3C;
        @(negedge clk);
        start1 = 1'b0;
        check_frame1(8'h3C, "3c", 1'b1, got);
        start1 = 1'b1;
        d1     = 8'hC3;
        @(negedge clk);
        start1 = 1'b0;
        check_frame1(8'hC3, "c3", 1'b0, got);
        @(negedge clk);
        chk("c3 done single", 32'(done1), 32'd0);

        // 5: reset during data bit 3 abandons the frame
        start1 = 1'b1;
        d1     = 8'h00;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort before rst tx", 32'(tx1), 32'd0);
        chk("abort before rst busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort rst tx", 32'(tx1), 32'd1);
        chk("abort rst busy", 32'(busy1), 32'd0);
        chk("abort rst done", 32'(done1), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("abort quiet done c%0d", i), 32'(done1), 32'd0);
            chk($sformatf("abort quiet tx c%0d", i), 32'(tx1), 32'd1);
        end
        start1 = 1'b1;
        d1     = 8'h55;
        @(negedge clk);
        start1 = 1'b0;
        check_frame1(8'h55, "55", 1'b0, got);

        // 6: parity-bearing patterns (plain frames without the feature)
        @(negedge clk);
        start1 = 1'b1;
        d1     = 8'h07;
        @(negedge clk);
        start1 = 1'b0;
        check_frame1(8'h07, "07", 1'b0, got);
`ifdef UART_TX_PARITY_EN
        chk("07 parity bit", 32'(got[9]), 32'd1);
`else
        chk("07 frame bits", 32'(got[9:0]), 32'(10'b1000001110));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
